// File: rtl/xor_up_absorb_if.sv
`default_nettype none
// ============================================================================
// Module      : xor_up_absorb_if
// Description : Handshake/data bundle between the rate-side XOR block, the
//               permutation core and the controller. The state is carried as
//               five 64-bit words, word 0 being the rate word S[0].
// Revision    : 1.0 - initial release
// ============================================================================
interface xor_up_absorb_if;
  logic                start_i;
  logic                mode_i;
  logic [127:0]        key_i;
  logic [4:0][63:0]    state_i;
  logic                perm_done_i;
  logic [63:0]         data_i;
  logic                data_valid_i;
  logic                last_i;
  logic                data_ready_o;
  logic [4:0][63:0]    state_o;
  logic                perm_start_o;
  logic [63:0]         dout_o;
  logic                dout_valid_o;
  logic [127:0]        tag_o;
  logic                tag_valid_o;
  logic                busy_o;
  logic                error_o;

  // The absorb block itself
  modport slave (
    input  start_i, mode_i, key_i, state_i, perm_done_i, data_i, data_valid_i, last_i,
    output data_ready_o, state_o, perm_start_o, dout_o, dout_valid_o, tag_o,
           tag_valid_o, busy_o, error_o
  );

  // Controller / permutation side
  modport master (
    output start_i, mode_i, key_i, state_i, perm_done_i, data_i, data_valid_i, last_i,
    input  data_ready_o, state_o, perm_start_o, dout_o, dout_valid_o, tag_o,
           tag_valid_o, busy_o, error_o
  );
endinterface
`default_nettype wire

// File: rtl/xor_up_absorb.sv
`default_nettype none
// ============================================================================
// Module      : xor_up_absorb
// Description : Rate-side absorb/squeeze stage. Owns the working state,
//               XORs data blocks into S[0], emits cipher/plain words, injects
//               the key into S[1]/S[2] before finalisation, produces the tag
//               and drives the permutation through a start/done handshake
//               guarded by a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module xor_up_absorb #(
  parameter int RATE_W       = 64,
  parameter int PERM_TIMEOUT = 64
) (
  input  wire logic      clock_i,
  input  wire logic      resetb_i,
  xor_up_absorb_if.slave bus
);

  // Only a 64-bit rate is supported; stop elaboration for anything else.
  if (RATE_W != 64) begin : g_rate_check
    $error("xor_up_absorb: RATE_W must be 64");
  end

  localparam bit c_wd_en  = (PERM_TIMEOUT != 0);
  localparam int c_cnt_w  = (PERM_TIMEOUT > 1) ? $clog2(PERM_TIMEOUT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((PERM_TIMEOUT > 0) ? PERM_TIMEOUT - 1 : 0);
  localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ABSORB = 2'd1,
    ST_PERM   = 2'd2,
    ST_FINAL  = 2'd3
  } state_t;

  state_t             r_fsm;
  state_t             w_fsm_next;
  logic               w_xfer;
  logic               w_done;
  logic               w_timeout;
  logic [63:0]        w_cipher;

  logic [4:0][63:0]   r_state;
  logic [127:0]       r_key;
  logic               r_mode;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_data_ready;
  logic               r_perm_start;
  logic [63:0]        r_dout;
  logic               r_dout_valid;
  logic [127:0]       r_tag;
  logic               r_tag_valid;
  logic               r_error;

  assign w_cipher = r_state[0] ^ bus.data_i;

  // Next-state decode; done takes priority over a simultaneous timeout.
  always_comb begin
    w_fsm_next = r_fsm;
    w_xfer     = 1'b0;
    w_done     = 1'b0;
    w_timeout  = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (bus.start_i) w_fsm_next = ST_ABSORB;
      end
      ST_ABSORB: begin
        if (bus.data_valid_i && r_data_ready) begin
          w_xfer     = 1'b1;
          w_fsm_next = bus.last_i ? ST_FINAL : ST_PERM;
        end
      end
      ST_PERM, ST_FINAL: begin
        if (bus.perm_done_i) begin
          w_done     = 1'b1;
          w_fsm_next = (r_fsm == ST_PERM) ? ST_ABSORB : ST_IDLE;
        end else if (c_wd_en && (r_cnt == c_cnt_last)) begin
          w_timeout  = 1'b1;
          w_fsm_next = ST_IDLE;
        end
      end
      default: w_fsm_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) r_fsm <= ST_IDLE;
    else           r_fsm <= w_fsm_next;
  end

  // Watchdog counter: cleared by the transfer that enters PERM/FINAL, saturating.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= '0;
    end else if (((r_fsm == ST_PERM) || (r_fsm == ST_FINAL)) && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  // Working state, key/mode capture, output registers and one-cycle pulses.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state      <= '0;
      r_key        <= '0;
      r_mode       <= 1'b0;
      r_data_ready <= 1'b0;
      r_perm_start <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_tag        <= '0;
      r_tag_valid  <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      r_perm_start <= 1'b0;
      r_tag_valid  <= 1'b0;
      r_error      <= 1'b0;
      r_data_ready <= (w_fsm_next == ST_ABSORB);

      if ((r_fsm == ST_IDLE) && bus.start_i) begin
        r_state <= bus.state_i;
        r_key   <= bus.key_i;
        r_mode  <= bus.mode_i;
        r_tag   <= '0;
      end

      if (w_xfer) begin
        r_dout       <= w_cipher;
        r_dout_valid <= 1'b1;
        r_perm_start <= 1'b1;
        // Decrypt keeps the ciphertext so both sides evolve the same state.
        r_state[0]   <= r_mode ? bus.data_i : w_cipher;
        if (bus.last_i) begin
          r_state[1] <= r_state[1] ^ r_key[127:64];
          r_state[2] <= r_state[2] ^ r_key[63:0];
        end
      end

      if (w_done) begin
        r_state <= bus.state_i;
        if (r_fsm == ST_FINAL) begin
          r_tag       <= {bus.state_i[3] ^ r_key[127:64], bus.state_i[4] ^ r_key[63:0]};
          r_tag_valid <= 1'b1;
        end
      end

      if (w_timeout) r_error <= 1'b1;
    end
  end

  assign bus.data_ready_o = r_data_ready;
  assign bus.state_o      = r_state;
  assign bus.perm_start_o = r_perm_start;
  assign bus.dout_o       = r_dout;
  assign bus.dout_valid_o = r_dout_valid;
  assign bus.tag_o        = r_tag;
  assign bus.tag_valid_o  = r_tag_valid;
  assign bus.busy_o       = (r_fsm != ST_IDLE);
  assign bus.error_o      = r_error;

endmodule
`default_nettype wire
